// File: rtl/prewish_controller.sv
`timescale 1ns/100ps
// rtl/prewish_controller.sv - prewish blinky top: clock buffer, stretched reset, mask strobe, LED player
module prewish_controller #(
  parameter int NEWMASK_CLK_BITS = 26,
  parameter int RESET_CYCLES     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       CLK_O,
  output logic       RST_O,
  output logic       o_stb,
  output logic [7:0] o_data,
  output logic       o_led
);

  localparam int BLINK_BITS = NEWMASK_CLK_BITS - 4;
  localparam logic [7:0] RESET_LAST = 8'(RESET_CYCLES - 1);

  logic [7:0]                  rst_cnt;
  logic [NEWMASK_CLK_BITS-1:0] nm_cnt;
  logic [BLINK_BITS-1:0]       pre;
  logic [1:0]                  idx;
  logic [7:0]                  mask;
  logic [2:0]                  bit_idx;

  // Stands in for the SB_GB global buffer; the clock passes through untouched.
  assign CLK_O = i_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_cnt <= '0;
      RST_O   <= 1'b1;
    end else if (RST_O) begin
      if (rst_cnt == RESET_LAST) begin
        RST_O <= 1'b0;
      end else begin
        rst_cnt <= rst_cnt + 8'd1;
      end
    end
  end

  assign o_stb = !RST_O && (&nm_cnt);

  always_comb begin
    o_data = 8'h00;
    case (idx)
      2'd0: o_data = 8'b1010_1000;
      2'd1: o_data = 8'b1100_1010;
      2'd2: o_data = 8'b1111_0000;
      2'd3: o_data = 8'b1000_0000;
      default: o_data = 8'h00;
    endcase
  end

  // A load and the last pre-tick of a period coincide; the load wins so slot 0 restarts at bit 7.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nm_cnt  <= '0;
      pre     <= '0;
      idx     <= 2'd0;
      mask    <= 8'h00;
      bit_idx <= 3'd7;
    end else if (RST_O) begin
      nm_cnt  <= '0;
      pre     <= '0;
      idx     <= 2'd0;
      mask    <= 8'h00;
      bit_idx <= 3'd7;
    end else begin
      nm_cnt <= nm_cnt + 1'b1;
      if (o_stb) begin
        mask    <= o_data;
        idx     <= idx + 2'd1;
        bit_idx <= 3'd7;
        pre     <= '0;
      end else begin
        pre <= pre + 1'b1;
        if (&pre) begin
          bit_idx <= bit_idx - 3'd1;
        end
      end
    end
  end

  assign o_led = mask[bit_idx];

endmodule

// File: tb/tb_prewish_controller.sv
`timescale 1ns/100ps
// tb/tb_prewish_controller.sv - directed self-checking bench for prewish_controller
module tb_prewish_controller;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_o;
  logic       rst_o;
  logic       stb;
  logic [7:0] data;
  logic       led;

  int checks = 0;
  int fails  = 0;

  prewish_controller #(
    .NEWMASK_CLK_BITS(9),
    .RESET_CYCLES(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .CLK_O  (clk_o),
    .RST_O  (rst_o),
    .o_stb  (stb),
    .o_data (data),
    .o_led  (led)
  );

  always #1 clk = ~clk;

  task automatic test_clock_pass(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #0.2;
      checks++;
      if (clk_o !== 1'b1) begin
        fails++;
        $display("FAIL clk_pass_high: CLK_O=%b expected 1", clk_o);
      end
      @(negedge clk);
      #0.2;
      checks++;
      if (clk_o !== 1'b0) begin
        fails++;
        $display("FAIL clk_pass_low: CLK_O=%b expected 0", clk_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rst_o !== 1'b1 || stb !== 1'b0 || led !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: RST_O=%b o_stb=%b o_led=%b expected 1/0/0", rst_o, stb, led);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (rst_o !== (i < 4) || stb !== 1'b0 || led !== 1'b0) begin
        fails++;
        $display("FAIL reset_stretch edge %0d: RST_O=%b o_stb=%b o_led=%b expected %b/0/0",
                 i, rst_o, stb, led, (i < 4));
      end
    end
  endtask

  task automatic test_first_strobe();
    int extra;
    int led_bad;
    extra   = 0;
    led_bad = 0;
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      if (stb !== 1'b0) extra++;
      if (led !== 1'b0) led_bad++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL first_strobe_early: %0d strobes seen expected 0", extra);
    end
    checks++;
    if (led_bad != 0) begin
      fails++;
      $display("FAIL led_before_load: %0d cycles lit expected 0", led_bad);
    end
    @(negedge clk);
    checks++;
    if (stb !== 1'b1 || data !== 8'hA8) begin
      fails++;
      $display("FAIL first_strobe: o_stb=%b o_data=%h expected 1/a8", stb, data);
    end
  endtask

  task automatic test_blink();
    logic [15:0] pat;
    int          stray;
    logic        exp_led;
    pat   = 16'hA8A8;
    stray = 0;
    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      exp_led = pat[15 - j / 32];
      checks++;
      if (led !== exp_led) begin
        fails++;
        $display("FAIL blink cycle %0d slot %0d: o_led=%b expected %b", j, j / 32, led, exp_led);
      end
      if (j < 511 && stb !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      fails++;
      $display("FAIL blink_stray_strobe: %0d strobes expected 0", stray);
    end
    checks++;
    if (stb !== 1'b1 || data !== 8'hCA) begin
      fails++;
      $display("FAIL second_strobe: o_stb=%b o_data=%h expected 1/ca", stb, data);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] exp_seq [6];
    int got;
    int gap;
    exp_seq = '{8'hF0, 8'h80, 8'hA8, 8'hCA, 8'hF0, 8'h80};
    got = 0;
    gap = 0;
    for (int c = 0; c < 3555 && got < 6; c++) begin
      @(negedge clk);
      gap++;
      if (stb === 1'b1) begin
        checks++;
        if (data !== exp_seq[got]) begin
          fails++;
          $display("FAIL seq_data #%0d: o_data=%h expected %h", got, data, exp_seq[got]);
        end
        checks++;
        if (gap != 512) begin
          fails++;
          $display("FAIL seq_spacing #%0d: gap=%0d expected 512", got, gap);
        end
        got++;
        gap = 0;
      end
    end
    checks++;
    if (got != 6) begin
      fails++;
      $display("FAIL seq_count: %0d strobes expected 6", got);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit found;
    repeat (10) @(negedge clk);
    checks++;
    if (led !== 1'b1) begin
      fails++;
      $display("FAIL mid_blink_led: o_led=%b expected 1", led);
    end
    #0.5;
    rst_n = 1'b0;
    #0.2;
    checks++;
    if (rst_o !== 1'b1 || led !== 1'b0 || stb !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: RST_O=%b o_led=%b o_stb=%b expected 1/0/0", rst_o, led, stb);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 600 && !found) begin
      @(negedge clk);
      n++;
      if (stb === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != 515) begin
      fails++;
      $display("FAIL restart_strobe_time: found=%0d after %0d cycles expected 515", found, n);
    end
    checks++;
    if (data !== 8'hA8) begin
      fails++;
      $display("FAIL restart_strobe_data: o_data=%h expected a8", data);
    end
  endtask

  initial begin
    test_clock_pass(2);
    test_reset();
    test_first_strobe();
    test_blink();
    test_seq_wrap();
    test_mid_reset();
    test_clock_pass(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
